mlp_host_sequencer: RTL and testbench
=====================================

MLP_HOST_SEQUENCER -- requirements
Module: mlp_host_sequencer

Interface
REQ-001 SHALL have parameter N_INPUTS, default 2, input vector length.
REQ-002 SHALL have parameter N_HIDDEN, default 4, hidden neuron count.
REQ-003 SHALL have parameter OUT_WIDTH, default 16, result width; N_OUTPUT is fixed at 1.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 4096, DONE-poll limit in clocks.
REQ-005 SHALL use one clock; reset is synchronous and active-high. Ports: clk  in  1  clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle job request; accepted only in IDLE.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 s_valid  in  1 / s_ready  out  1 / s_data  in  32  parameter word stream.
REQ-010 res_valid  out  1 / res_ready  in  1 / res_data  out  OUT_WIDTH  result; res_err  out  1  timeout flag.
REQ-011 m_write_en  out  1 / m_addr  out  2 / m_writedata  out  32  register-bus master to the mlp accelerator.
REQ-012 m_readdata  in  32  registered read data; it reflects m_addr as presented one cycle earlier.

Function
REQ-013 The stream word order SHALL be: N_INPUTS inputs, then per hidden neuron {bias, w0..w(N_INPUTS-1)}, then output {bias, w0..w(N_HIDDEN-1)}; total W = N_INPUTS + N_HIDDEN*(N_INPUTS+1) + N_HIDDEN+1 (19 at defaults).
REQ-014 Register map: CTRL=0, INPUT_FIFO=1, WEIGHT_FIFO=2, OUTPUT=3; CTRL bits RUN=0, DONE=1, IRQ_EN=2 (always written 0), LAYER_SEL=3.
REQ-015 FSM states SHALL be IDLE, LOAD_IN, LOAD_HID, SEL_OUT, LOAD_OUT, RUN, POLL, READ, RESULT.
REQ-016 IDLE->LOAD_IN on start; start while busy SHALL be ignored.
REQ-017 Each bus write SHALL be a one-cycle m_write_en pulse followed by at least one cycle with m_write_en=0, giving at most one write per 2 clocks.
REQ-018 s_ready SHALL be high only in load states on a cycle in which a write can issue; a word SHALL be written on the cycle after s_valid&&s_ready.
REQ-019 LOAD_IN writes N_INPUTS words to addr 1; LOAD_HID writes N_HIDDEN*(N_INPUTS+1) words to addr 2; a word counter SHALL select the transitions.
REQ-020 SEL_OUT SHALL write 0x00000008 to addr 0 with no stream word consumed; then LOAD_OUT writes N_HIDDEN+1 words to addr 2.
REQ-021 RUN SHALL write 0x00000001 to addr 0, then enter POLL holding m_addr=0.
REQ-022 POLL SHALL sample m_readdata[1] every cycle from the second POLL cycle; on 1 it SHALL go to READ.
REQ-023 A POLL cycle counter SHALL go to RESULT with res_err=1 and res_data=0 when it reaches TIMEOUT_CYCLES without DONE.
REQ-024 READ SHALL drive m_addr=3 for one cycle, capture m_readdata[OUT_WIDTH-1:0] on the next cycle, and go to RESULT with res_err=0.
REQ-025 RESULT holds res_valid=1 with stable res_data/res_err until res_ready; on handshake it goes to IDLE, deasserts busy that cycle, and the next job starts with LAYER_SEL=0 via a write of 0x00000000 to addr 0 before LOAD_IN.
REQ-026 Stalls on s_valid SHALL pause loading indefinitely with m_write_en=0; no timeout applies to loading.
REQ-027 m_writedata SHALL carry the stream word unmodified (32 bits).

Reset
REQ-028 On rst: state IDLE; busy, s_ready, m_write_en, res_valid, res_err =0; m_addr=0; m_writedata=0; res_data=0; counters cleared; rst mid-job aborts immediately with no further bus writes.

Verification
REQ-029 Nominal: start, 19 words streamed back-to-back, mock mlp raises DONE 30 cycles after RUN, OUTPUT=0x0180 -> write trace addr 0 (0x0), 1,1, 2x12, 0 (0x8), 2x5, 0 (0x1); res_data=0x0180, res_err=0.
REQ-030 Spacing: check no two m_write_en pulses are on adjacent cycles; 22 writes total.
REQ-031 Stream stall: s_valid low for 10 cycles after word 7 -> no writes during the stall, trace identical to REQ-029.
REQ-032 Timeout: mock never sets DONE, TIMEOUT_CYCLES=64 -> res_valid with res_err=1, res_data=0 after 64 POLL cycles.
REQ-033 Backpressure/restart: res_ready low 5 cycles -> res_data stable; start during RESULT ignored; second job runs correctly.
REQ-034 Reset mid-LOAD_HID -> outputs at reset values next cycle; a new job replays the full trace.

Source files
------------

// File: rtl/mlp_host_sequencer.sv
// Host-side sequencer that streams inputs and weights into the mlp accelerator over its
// register bus, starts a run, polls for DONE and returns the single output (or a timeout flag).
module mlp_host_sequencer #(
   parameter int N_INPUTS       = 2,
   parameter int N_HIDDEN       = 4,
   parameter int OUT_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [31:0]          s_data,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [OUT_WIDTH-1:0] res_data,
   output logic                 res_err,
   output logic                 m_write_en,
   output logic [1:0]           m_addr,
   output logic [31:0]          m_writedata,
   input  logic [31:0]          m_readdata
);

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_INPUT  = 2'd1;
   localparam logic [1:0] ADDR_WEIGHT = 2'd2;
   localparam logic [1:0] ADDR_OUTPUT = 2'd3;

   localparam logic [31:0] CTRL_CLEAR     = 32'h0000_0000;
   localparam logic [31:0] CTRL_LAYER_OUT = 32'h0000_0008;
   localparam logic [31:0] CTRL_RUN       = 32'h0000_0001;

   localparam int N_HID_WORDS = N_HIDDEN * (N_INPUTS + 1);
   localparam int N_OUT_WORDS = N_HIDDEN + 1;
   localparam int MAX_WORDS   = (N_HID_WORDS > N_INPUTS) ?
                                ((N_HID_WORDS > N_OUT_WORDS) ? N_HID_WORDS : N_OUT_WORDS) :
                                ((N_INPUTS > N_OUT_WORDS) ? N_INPUTS : N_OUT_WORDS);
   localparam int CNT_W  = $clog2(MAX_WORDS + 1);
   localparam int POLL_W = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [CNT_W-1:0]  LAST_IN   = CNT_W'(N_INPUTS - 1);
   localparam logic [CNT_W-1:0]  LAST_HID  = CNT_W'(N_HID_WORDS - 1);
   localparam logic [CNT_W-1:0]  LAST_OUT  = CNT_W'(N_OUT_WORDS - 1);
   localparam logic [POLL_W-1:0] LAST_POLL = POLL_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [3:0] {
      IDLE, LOAD_IN, LOAD_HID, SEL_OUT, LOAD_OUT, RUN, POLL, READ, RESULT
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      word_cnt_q, word_cnt_d;
   logic [POLL_W-1:0]     poll_cnt_q, poll_cnt_d;
   logic                  read_phase_q, read_phase_d;
   logic                  m_write_en_q, m_write_en_d;
   logic [1:0]            m_addr_q, m_addr_d;
   logic [31:0]           m_writedata_q, m_writedata_d;
   logic                  res_valid_q, res_valid_d;
   logic                  res_err_q, res_err_d;
   logic [OUT_WIDTH-1:0]  res_data_q, res_data_d;
   logic                  load_state;
   logic                  load_hs;

   // A write slot exists only when the previous cycle carried no pulse, which enforces the gap.
   assign load_state = (state_q == LOAD_IN) || (state_q == LOAD_HID) || (state_q == LOAD_OUT);
   assign s_ready    = load_state && !m_write_en_q;
   assign load_hs    = s_valid && s_ready;
   assign busy       = (state_q != IDLE);

   assign m_write_en  = m_write_en_q;
   assign m_addr      = m_addr_q;
   assign m_writedata = m_writedata_q;
   assign res_valid   = res_valid_q;
   assign res_err     = res_err_q;
   assign res_data    = res_data_q;

   always_comb begin
      // NOTE: every signal gets a default first so no path through the case infers a latch.
      state_d       = state_q;
      word_cnt_d    = word_cnt_q;
      poll_cnt_d    = poll_cnt_q;
      read_phase_d  = read_phase_q;
      m_write_en_d  = 1'b0;
      m_addr_d      = m_addr_q;
      m_writedata_d = m_writedata_q;
      res_valid_d   = res_valid_q;
      res_err_d     = res_err_q;
      res_data_d    = res_data_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d       = LOAD_IN;
               word_cnt_d    = '0;
               m_write_en_d  = 1'b1;
               m_addr_d      = ADDR_CTRL;
               m_writedata_d = CTRL_CLEAR;
            end
         end
         LOAD_IN: begin
            if (load_hs) begin
               m_write_en_d  = 1'b1;
               m_addr_d      = ADDR_INPUT;
               m_writedata_d = s_data;
               if (word_cnt_q == LAST_IN) begin
                  word_cnt_d = '0;
                  state_d    = LOAD_HID;
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
               end
            end
         end
         LOAD_HID: begin
            if (load_hs) begin
               m_write_en_d  = 1'b1;
               m_addr_d      = ADDR_WEIGHT;
               m_writedata_d = s_data;
               if (word_cnt_q == LAST_HID) begin
                  word_cnt_d = '0;
                  state_d    = SEL_OUT;
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
               end
            end
         end
         SEL_OUT: begin
            if (!m_write_en_q) begin
               m_write_en_d  = 1'b1;
               m_addr_d      = ADDR_CTRL;
               m_writedata_d = CTRL_LAYER_OUT;
               state_d       = LOAD_OUT;
            end
         end
         LOAD_OUT: begin
            if (load_hs) begin
               m_write_en_d  = 1'b1;
               m_addr_d      = ADDR_WEIGHT;
               m_writedata_d = s_data;
               if (word_cnt_q == LAST_OUT) begin
                  word_cnt_d = '0;
                  state_d    = RUN;
               end else begin
                  word_cnt_d = word_cnt_q + 1'b1;
               end
            end
         end
         RUN: begin
            if (!m_write_en_q) begin
               m_write_en_d  = 1'b1;
               m_addr_d      = ADDR_CTRL;
               m_writedata_d = CTRL_RUN;
               poll_cnt_d    = '0;
               state_d       = POLL;
            end
         end
         POLL: begin
            // Read data lags the address by a cycle, so the first POLL cycle is not trusted.
            if ((poll_cnt_q != '0) && m_readdata[1]) begin
               m_addr_d     = ADDR_OUTPUT;
               read_phase_d = 1'b0;
               state_d      = READ;
            end else if (poll_cnt_q == LAST_POLL) begin
               res_valid_d = 1'b1;
               res_err_d   = 1'b1;
               res_data_d  = '0;
               state_d     = RESULT;
            end else begin
               poll_cnt_d = poll_cnt_q + 1'b1;
            end
         end
         READ: begin
            if (!read_phase_q) begin
               read_phase_d = 1'b1;
               m_addr_d     = ADDR_CTRL;
            end else begin
               res_valid_d = 1'b1;
               res_err_d   = 1'b0;
               res_data_d  = m_readdata[OUT_WIDTH-1:0];
               state_d     = RESULT;
            end
         end
         RESULT: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (rst) begin
         state_q       <= IDLE;
         word_cnt_q    <= '0;
         poll_cnt_q    <= '0;
         read_phase_q  <= 1'b0;
         m_write_en_q  <= 1'b0;
         m_addr_q      <= '0;
         m_writedata_q <= '0;
         res_valid_q   <= 1'b0;
         res_err_q     <= 1'b0;
         res_data_q    <= '0;
      end else begin
         state_q       <= state_d;
         word_cnt_q    <= word_cnt_d;
         poll_cnt_q    <= poll_cnt_d;
         read_phase_q  <= read_phase_d;
         m_write_en_q  <= m_write_en_d;
         m_addr_q      <= m_addr_d;
         m_writedata_q <= m_writedata_d;
         res_valid_q   <= res_valid_d;
         res_err_q     <= res_err_d;
         res_data_q    <= res_data_d;
      end
   end

endmodule

// File: tb/tb_mlp_host_sequencer.sv
// Directed bench for mlp_host_sequencer: a mock accelerator answers the register bus and a
// scoreboard compares every bus write against the trace expected for the words streamed in.
module tb_mlp_host_sequencer;

   localparam int N_IN  = 2;
   localparam int N_HID = 4;
   localparam int OW    = 16;
   localparam int TO    = 64;
   localparam int NW    = N_IN + N_HID * (N_IN + 1) + N_HID + 1;
   localparam int NWR   = NW + 3;

   typedef struct packed {
      logic [1:0]  addr;
      logic [31:0] data;
   } wr_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          busy;
   logic          s_valid;
   logic          s_ready;
   logic [31:0]   s_data;
   logic          res_valid;
   logic          res_ready;
   logic [OW-1:0] res_data;
   logic          res_err;
   logic          m_write_en;
   logic [1:0]    m_addr;
   logic [31:0]   m_writedata;
   logic [31:0]   m_readdata = 32'h0;

   int errors = 0;
   int checks = 0;

   int          cyc = 0;
   logic        run_seen = 1'b0;
   logic        done = 1'b0;
   int          run_cyc = 0;
   logic        never_done = 1'b0;
   logic [15:0] out_val = 16'h0;

   logic [31:0] words [NW];
   wr_t         exp_q [$];
   wr_t         obs_q [$];
   int          obs_cyc [$];

   always #5 clk = ~clk;

   mlp_host_sequencer #(
      .N_INPUTS(N_IN), .N_HIDDEN(N_HID), .OUT_WIDTH(OW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
      .m_write_en(m_write_en), .m_addr(m_addr), .m_writedata(m_writedata),
      .m_readdata(m_readdata)
   );

   // Mock accelerator: CTRL writes restart it, DONE rises 30 cycles after RUN, read data registered.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_write_en && m_addr == 2'd0) begin
         run_seen <= m_writedata[0];
         run_cyc  <= cyc;
         done     <= 1'b0;
      end else if (run_seen && !never_done && (cyc - run_cyc >= 30)) begin
         done <= 1'b1;
      end
      case (m_addr)
         2'd0:    m_readdata <= {30'h0, done, run_seen};
         2'd3:    m_readdata <= {16'h0, out_val};
         default: m_readdata <= 32'h0;
      endcase
   end

   always @(negedge clk) begin
      if (m_write_en) begin
         obs_q.push_back('{addr: m_addr, data: m_writedata});
         obs_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'(0));
      check({tag, "_s_ready"}, 64'(s_ready), 64'(0));
      check({tag, "_m_write_en"}, 64'(m_write_en), 64'(0));
      check({tag, "_res_valid"}, 64'(res_valid), 64'(0));
      check({tag, "_res_err"}, 64'(res_err), 64'(0));
      check({tag, "_m_addr"}, 64'(m_addr), 64'(0));
      check({tag, "_m_writedata"}, 64'(m_writedata), 64'(0));
      check({tag, "_res_data"}, 64'(res_data), 64'(0));
   endtask

   // Draw fresh stream words and push the full bus trace they must produce.
   task automatic prepare_job();
      int k;
      for (int i = 0; i < NW; i++) words[i] = $urandom;
      exp_q.delete();
      obs_q.delete();
      obs_cyc.delete();
      k = 0;
      exp_q.push_back('{addr: 2'd0, data: 32'h0});
      for (int i = 0; i < N_IN; i++) exp_q.push_back('{addr: 2'd1, data: words[k++]});
      for (int i = 0; i < N_HID * (N_IN + 1); i++) exp_q.push_back('{addr: 2'd2, data: words[k++]});
      exp_q.push_back('{addr: 2'd0, data: 32'h8});
      for (int i = 0; i < N_HID + 1; i++) exp_q.push_back('{addr: 2'd2, data: words[k++]});
      exp_q.push_back('{addr: 2'd0, data: 32'h1});
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic stream(input int n_send, input int stall_after);
      int n;
      for (int i = 0; i < n_send; i++) begin
         if (i == stall_after) begin
            s_valid = 1'b0;
            repeat (10) @(negedge clk);
            check("stall_no_writes", 64'(obs_q.size()), 64'(stall_after + 1));
         end
         s_data  = words[i];
         s_valid = 1'b1;
         n = 0;
         while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         if (!s_ready) begin
            check("s_ready_timeout", 64'(s_ready), 64'(1));
            s_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      s_valid = 1'b0;
   endtask

   task automatic finish_job(input logic exp_err, input logic [15:0] exp_data, input int hold);
      int   n;
      int   vcyc;
      int   min_gap;
      wr_t  e;
      wr_t  o;
      logic [OW-1:0] held;
      n = 0;
      while (!res_valid && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("res_valid_seen", 64'(res_valid), 64'(1));
      vcyc = cyc;
      check("res_err", 64'(res_err), 64'(exp_err));
      check("res_data", 64'(res_data), 64'(exp_data));
      if (exp_err && obs_cyc.size() > 0)
         check("timeout_latency", 64'(vcyc - obs_cyc[obs_cyc.size() - 1]), 64'(TO));
      held = res_data;
      for (int i = 0; i < hold; i++) begin
         if (i == 2) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         check("hold_res_valid", 64'(res_valid), 64'(1));
         check("hold_res_data", 64'(res_data), 64'(held));
         check("hold_busy", 64'(busy), 64'(1));
      end
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      check("post_handshake_busy", 64'(busy), 64'(0));
      check("post_handshake_res_valid", 64'(res_valid), 64'(0));
      repeat (4) @(negedge clk);
      check("write_count", 64'(obs_q.size()), 64'(NWR));
      min_gap = 1000;
      for (int i = 1; i < obs_cyc.size(); i++)
         if (obs_cyc[i] - obs_cyc[i - 1] < min_gap) min_gap = obs_cyc[i] - obs_cyc[i - 1];
      check("write_spacing_ok", 64'(min_gap >= 2), 64'(1));
      while (exp_q.size() > 0 && obs_q.size() > 0) begin
         e = exp_q.pop_front();
         o = obs_q.pop_front();
         check("bus_write", 64'(o), 64'(e));
      end
   endtask

   task automatic run_job(input int stall_after, input logic exp_err,
                          input logic [15:0] exp_data, input int hold);
      prepare_job();
      pulse_start();
      check("busy_after_start", 64'(busy), 64'(1));
      stream(NW, stall_after);
      finish_job(exp_err, exp_data, hold);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      s_valid   = 1'b0;
      s_data    = 32'h0;
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      @(negedge clk);

      out_val = 16'h0180;
      run_job(-1, 1'b0, 16'h0180, 0);

      out_val = 16'hA5C3;
      run_job(7, 1'b0, 16'hA5C3, 0);

      never_done = 1'b1;
      run_job(-1, 1'b1, 16'h0000, 0);
      never_done = 1'b0;

      out_val = 16'h1234;
      run_job(-1, 1'b0, 16'h1234, 5);

      out_val = 16'h7E01;
      run_job(-1, 1'b0, 16'h7E01, 0);

      prepare_job();
      pulse_start();
      stream(5, -1);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("mid_job_reset");
      rst = 1'b0;
      obs_q.delete();
      obs_cyc.delete();
      repeat (20) @(negedge clk);
      check("no_writes_after_reset", 64'(obs_q.size()), 64'(0));

      out_val = 16'h0042;
      run_job(-1, 1'b0, 16'h0042, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
